rst_mp: RTL and testbench

RST_MP -- requirements
Module: rst_mp

---
 rtl/rst_mp_if.sv | 39 +++
 rtl/rst_mp.sv | 144 ++++++++++++++
 tb/tb_rst_mp.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rst_mp_if.sv
// rst_mp_if: dispatch / writeback / branch / lookup bundle for the register status table.
interface rst_mp_if #(
  parameter int NREGS = 32,
  parameter int TAG_W = 4,
  parameter int NDISP = 2,
  parameter int NWB   = 2,
  parameter int NRD   = 4,
  parameter int NBR   = 4
);
  localparam int SEL_W = $clog2(NREGS);
  localparam int BR_W  = (NBR > 1) ? $clog2(NBR) : 1;

  logic [NDISP-1:0]            di_write;
  logic [NDISP-1:0][SEL_W-1:0] di_sel;
  logic [NDISP-1:0][TAG_W-1:0] di_tag;
  logic [NDISP-1:0][NBR-1:0]   di_mask;
  logic [NWB-1:0]              wb_write;
  logic [NWB-1:0][SEL_W-1:0]   wb_sel;
  logic [NWB-1:0][TAG_W-1:0]   wb_tag;
  logic                        br_valid;
  logic [BR_W-1:0]             br_id;
  logic                        br_squash;
  logic [NRD-1:0][SEL_W-1:0]   rd_sel;
  logic [NRD-1:0]              rd_busy;
  logic [NRD-1:0][TAG_W-1:0]   rd_tag;
  logic [NRD-1:0][NBR-1:0]     rd_mask;
  logic [SEL_W:0]              busy_count;

  modport master (
    output di_write, di_sel, di_tag, di_mask, wb_write, wb_sel, wb_tag,
           br_valid, br_id, br_squash, rd_sel,
    input  rd_busy, rd_tag, rd_mask, busy_count
  );
  modport slave (
    input  di_write, di_sel, di_tag, di_mask, wb_write, wb_sel, wb_tag,
           br_valid, br_id, br_squash, rd_sel,
    output rd_busy, rd_tag, rd_mask, busy_count
  );
endinterface

// File: rtl/rst_mp.sv
// rst_mp: register status table {busy, tag, spec mask} with branch resolve/squash.
// Optional RST_MP_WB_BYPASS_EN: lookups see same-cycle matching writebacks and squashes.
module rst_mp_entry #(
  parameter int NREGS = 32,
  parameter int TAG_W = 4,
  parameter int NDISP = 2,
  parameter int NWB   = 2,
  parameter int NBR   = 4,
  parameter int IDX   = 1,
  localparam int SEL_W = $clog2(NREGS),
  localparam int BR_W  = (NBR > 1) ? $clog2(NBR) : 1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NDISP-1:0]            di_write,
  input  logic [NDISP-1:0][SEL_W-1:0] di_sel,
  input  logic [NDISP-1:0][TAG_W-1:0] di_tag,
  input  logic [NDISP-1:0][NBR-1:0]   di_mask,
  input  logic [NWB-1:0]              wb_write,
  input  logic [NWB-1:0][SEL_W-1:0]   wb_sel,
  input  logic [NWB-1:0][TAG_W-1:0]   wb_tag,
  input  logic                        br_valid,
  input  logic [BR_W-1:0]             br_id,
  input  logic                        br_squash,
  output logic                        rd_busy,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [NBR-1:0]              rd_mask,
  output logic                        nxt_busy
);
  logic             st_busy, b, sq_hit, wb_hit;
  logic [TAG_W-1:0] st_tag, t;
  logic [NBR-1:0]   st_mask, m, dm;

  always_comb begin
    sq_hit = br_valid & br_squash & st_mask[br_id];
    b = st_busy;
    t = st_tag;
    m = st_mask;
    dm = '0;
    if (sq_hit) begin
      b = 1'b0; t = '0; m = '0;
    end else if (br_valid && !br_squash) begin
      m[br_id] = 1'b0;
    end
    wb_hit = 1'b0;
    for (int j = 0; j < NWB; j++)
      if (wb_write[j] && wb_sel[j] == SEL_W'(IDX) && b && wb_tag[j] == t) wb_hit = 1'b1;
    if (wb_hit) begin
      b = 1'b0; t = '0; m = '0;
    end
    // ascending port order lets the youngest dispatch win
    for (int k = 0; k < NDISP; k++) begin
      dm = di_mask[k];
      if (br_valid && !br_squash) dm[br_id] = 1'b0;
      if (di_write[k] && di_sel[k] == SEL_W'(IDX) && !(br_valid && br_squash && di_mask[k][br_id])) begin
        b = 1'b1; t = di_tag[k]; m = dm;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_busy <= 1'b0;
      st_tag  <= '0;
      st_mask <= '0;
    end else begin
      st_busy <= b;
      st_tag  <= t;
      st_mask <= m;
    end
  end

  assign nxt_busy = b;
`ifdef RST_MP_WB_BYPASS_EN
  assign rd_busy = (sq_hit | wb_hit) ? 1'b0 : st_busy;
  assign rd_tag  = (sq_hit | wb_hit) ? '0 : st_tag;
  assign rd_mask = (sq_hit | wb_hit) ? '0 : st_mask;
`else
  assign rd_busy = st_busy;
  assign rd_tag  = st_tag;
  assign rd_mask = st_mask;
`endif
endmodule

module rst_mp #(
  parameter int NREGS = 32,
  parameter int TAG_W = 4,
  parameter int NDISP = 2,
  parameter int NWB   = 2,
  parameter int NRD   = 4,
  parameter int NBR   = 4
) (
  input logic    CLK,
  input logic    nRST,
  rst_mp_if.slave bus
);
  localparam int SEL_W = $clog2(NREGS);
  localparam int CNT_W = SEL_W + 1;

  logic [NREGS-1:0]            v_busy, n_busy;
  logic [NREGS-1:0][TAG_W-1:0] v_tag;
  logic [NREGS-1:0][NBR-1:0]   v_mask;
  logic [CNT_W-1:0]            cnt_nxt;

  for (genvar i = 0; i < NREGS; i++) begin : g_ent
    if (i == 0) begin : g_zero
      assign v_busy[i] = 1'b0;
      assign v_tag[i]  = '0;
      assign v_mask[i] = '0;
      assign n_busy[i] = 1'b0;
    end else begin : g_reg
      rst_mp_entry #(
        .NREGS(NREGS), .TAG_W(TAG_W), .NDISP(NDISP), .NWB(NWB), .NBR(NBR), .IDX(i)
      ) u_ent (
        .CLK(CLK), .nRST(nRST),
        .di_write(bus.di_write), .di_sel(bus.di_sel), .di_tag(bus.di_tag), .di_mask(bus.di_mask),
        .wb_write(bus.wb_write), .wb_sel(bus.wb_sel), .wb_tag(bus.wb_tag),
        .br_valid(bus.br_valid), .br_id(bus.br_id), .br_squash(bus.br_squash),
        .rd_busy(v_busy[i]), .rd_tag(v_tag[i]), .rd_mask(v_mask[i]), .nxt_busy(n_busy[i])
      );
    end
  end

  always_comb begin
    bus.rd_busy = '0;
    bus.rd_tag  = '0;
    bus.rd_mask = '0;
    for (int r = 0; r < NRD; r++) begin
      bus.rd_busy[r] = v_busy[bus.rd_sel[r]];
      bus.rd_tag[r]  = v_tag[bus.rd_sel[r]];
      bus.rd_mask[r] = v_mask[bus.rd_sel[r]];
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + CNT_W'(n_busy[i]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) bus.busy_count <= '0;
    else       bus.busy_count <= cnt_nxt;
  end
endmodule

// File: tb/tb_rst_mp.sv
// tb_rst_mp: vector table + scoreboard bench for rst_mp (default parameters).
module tb_rst_mp;
  typedef struct packed { logic w; logic [4:0] sel; logic [3:0] tag; logic [3:0] mask; } dop_t;
  typedef struct packed { logic w; logic [4:0] sel; logic [3:0] tag; } wop_t;
  typedef struct packed { logic v; logic sq; logic [1:0] id; } bop_t;
  typedef struct {
    dop_t d0, d1; wop_t w0, w1; bop_t br;
    logic [3:0][4:0] rs; logic [3:0][8:0] ex; int cnt;
  } vec_t;
  typedef struct { logic [3:0][8:0] ex; int cnt; } exp_t;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];
  dop_t dn;
  wop_t wn;
  bop_t bn;

  rst_mp_if bus ();
  rst_mp dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  function automatic dop_t D(int w, int s, int t, int m);
    D.w = 1'(w); D.sel = 5'(s); D.tag = 4'(t); D.mask = 4'(m);
  endfunction
  function automatic wop_t W(int w, int s, int t);
    W.w = 1'(w); W.sel = 5'(s); W.tag = 4'(t);
  endfunction
  function automatic bop_t B(int v, int sq, int id);
    B.v = 1'(v); B.sq = 1'(sq); B.id = 2'(id);
  endfunction
  function automatic logic [8:0] E(int b, int t, int m);
    return {1'(b), 4'(t), 4'(m)};
  endfunction
  function automatic vec_t mk(dop_t d0, dop_t d1, wop_t w0, wop_t w1, bop_t br,
                              int r0, int r1, int r2, int r3,
                              logic [8:0] e0, logic [8:0] e1, logic [8:0] e2, logic [8:0] e3, int cnt);
    mk.d0 = d0; mk.d1 = d1; mk.w0 = w0; mk.w1 = w1; mk.br = br;
    mk.rs = {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
    mk.ex = {e3, e2, e1, e0};
    mk.cnt = cnt;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.di_write = '0; bus.di_sel = '0; bus.di_tag = '0; bus.di_mask = '0;
    bus.wb_write = '0; bus.wb_sel = '0; bus.wb_tag = '0;
    bus.br_valid = 1'b0; bus.br_id = '0; bus.br_squash = 1'b0;
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    bus.di_write = {v.d1.w, v.d0.w};
    bus.di_sel[0] = v.d0.sel;  bus.di_sel[1] = v.d1.sel;
    bus.di_tag[0] = v.d0.tag;  bus.di_tag[1] = v.d1.tag;
    bus.di_mask[0] = v.d0.mask; bus.di_mask[1] = v.d1.mask;
    bus.wb_write = {v.w1.w, v.w0.w};
    bus.wb_sel[0] = v.w0.sel;  bus.wb_sel[1] = v.w1.sel;
    bus.wb_tag[0] = v.w0.tag;  bus.wb_tag[1] = v.w1.tag;
    bus.br_valid = v.br.v; bus.br_squash = v.br.sq; bus.br_id = v.br.id;
    for (int r = 0; r < 4; r++) bus.rd_sel[r] = v.rs[r];
    e.ex = v.ex; e.cnt = v.cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_out(string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({name, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int r = 0; r < 4; r++)
      chk($sformatf("%s rd%0d(r%0d)", name, r, bus.rd_sel[r]),
          {23'd0, bus.rd_busy[r], bus.rd_tag[r], bus.rd_mask[r]}, {23'd0, e.ex[r]});
    chk({name, " busy_count"}, 32'(bus.busy_count), 32'(e.cnt));
  endtask

  initial begin
    dn = D(0, 0, 0, 0); wn = W(0, 0, 0); bn = B(0, 0, 0);
    // state carries across rows
    vecs.push_back(mk(D(1,5,3,0), dn, wn, wn, bn, 5,0,0,0, E(1,3,0), 0, 0, 0, 1));
    vecs.push_back(mk(dn, dn, W(1,5,2), wn, bn, 5,0,0,0, E(1,3,0), 0, 0, 0, 1));
    vecs.push_back(mk(dn, dn, W(1,5,3), wn, bn, 5,0,0,0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(D(1,7,1,0), D(1,7,6,0), wn, wn, bn, 7,0,0,0, E(1,6,0), 0, 0, 0, 1));
    vecs.push_back(mk(D(1,3,2,1), D(1,4,4,2), wn, wn, bn, 3,4,7,0, E(1,2,1), E(1,4,2), E(1,6,0), 0, 3));
    vecs.push_back(mk(dn, dn, wn, wn, B(1,1,0), 3,4,7,0, 0, E(1,4,2), E(1,6,0), 0, 2));
    vecs.push_back(mk(dn, dn, wn, wn, B(1,0,1), 3,4,7,0, 0, E(1,4,0), E(1,6,0), 0, 2));
    vecs.push_back(mk(D(1,9,2,0), dn, wn, wn, bn, 9,0,0,0, E(1,2,0), 0, 0, 0, 3));
    vecs.push_back(mk(dn, D(1,9,5,0), W(1,9,2), wn, bn, 9,0,0,0, E(1,5,0), 0, 0, 0, 3));
    vecs.push_back(mk(D(1,0,7,0), dn, wn, wn, bn, 0,9,0,0, 0, E(1,5,0), 0, 0, 3));
    vecs.push_back(mk(D(1,10,1,4), D(1,11,2,1), wn, wn, B(1,1,2), 10,11,0,0, 0, E(1,2,1), 0, 0, 4));
    vecs.push_back(mk(D(1,12,3,9), dn, wn, wn, B(1,0,3), 12,11,0,0, E(1,3,1), E(1,2,1), 0, 0, 5));
    vecs.push_back(mk(dn, dn, W(1,12,1), W(1,12,3), bn, 12,11,0,0, 0, E(1,2,1), 0, 0, 4));
    vecs.push_back(mk(dn, dn, W(1,20,0), wn, bn, 20,0,0,0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(dn, dn, wn, wn, B(1,1,0), 11,4,7,9, 0, E(1,4,0), E(1,6,0), E(1,5,0), 3));

    idle();
    bus.rd_sel = '0;
    bus.rd_sel[0] = 5'd5; bus.rd_sel[1] = 5'd31;
    #1;
    chk("reset busy_count", 32'(bus.busy_count), 32'd0);
    chk("reset rd_busy", 32'(bus.rd_busy), 32'd0);
    chk("reset rd_tag", 32'(bus.rd_tag), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      apply(vecs[i]);
      @(posedge CLK);
      #1;
      idle();
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // fill r1..r10, then async reset mid-cycle
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      bus.di_write = 2'b01; bus.di_sel[0] = 5'(i); bus.di_tag[0] = 4'(i); bus.di_mask[0] = '0;
    end
    @(posedge CLK);
    #1;
    idle();
    bus.rd_sel[0] = 5'd1; bus.rd_sel[1] = 5'd5; bus.rd_sel[2] = 5'd9; bus.rd_sel[3] = 5'd10;
    #1;
    chk("fill busy_count", 32'(bus.busy_count), 32'd10);
    chk("fill rd_busy", 32'(bus.rd_busy), 32'hf);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("async rst busy_count", 32'(bus.busy_count), 32'd0);
    chk("async rst rd_busy", 32'(bus.rd_busy), 32'd0);
    chk("async rst rd_tag", 32'(bus.rd_tag), 32'd0);

    // dispatch present while reset releases lands on the first edge
    bus.di_write = 2'b01; bus.di_sel[0] = 5'd2; bus.di_tag[0] = 4'd9; bus.di_mask[0] = '0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    idle();
    bus.rd_sel[0] = 5'd2;
    #1;
    chk("post-rst dispatch rd0", {23'd0, bus.rd_busy[0], bus.rd_tag[0], bus.rd_mask[0]}, {23'd0, E(1,9,0)});
    chk("post-rst busy_count", 32'(bus.busy_count), 32'd1);

    @(negedge CLK);
    bus.wb_write = 2'b01; bus.wb_sel[0] = 5'd2; bus.wb_tag[0] = 4'd9;
    #1;
`ifdef RST_MP_WB_BYPASS_EN
    chk("bypass wb rd_busy", 32'(bus.rd_busy[0]), 32'd0);
`else
    chk("no-bypass wb rd_busy", 32'(bus.rd_busy[0]), 32'd1);
`endif
    chk("pre-edge busy_count", 32'(bus.busy_count), 32'd1);
    @(posedge CLK);
    #1;
    idle();
    #1;
    chk("wb clear rd_busy", 32'(bus.rd_busy[0]), 32'd0);
    chk("wb clear busy_count", 32'(bus.busy_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
